// File: rtl/isa_pkg.sv
// Shared ISA constants for the 16-bit 5-stage pipeline: opcodes, register indices,
// default instruction width and the NOP encoding.
package isa_pkg;

    localparam int DEFAULT_IW = 16;
    localparam int OPCODE_W   = 5;
    localparam int REG_W      = 3;

    // Opcode occupies the top OPCODE_W bits of an instruction word
    localparam logic [OPCODE_W-1:0] OP_NOP   = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_STORE = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_LOAD  = 5'd26;

    localparam logic [REG_W-1:0] gr0 = 3'd0;
    localparam logic [REG_W-1:0] gr1 = 3'd1;
    localparam logic [REG_W-1:0] gr2 = 3'd2;
    localparam logic [REG_W-1:0] gr3 = 3'd3;
    localparam logic [REG_W-1:0] gr4 = 3'd4;
    localparam logic [REG_W-1:0] gr5 = 3'd5;
    localparam logic [REG_W-1:0] gr6 = 3'd6;
    localparam logic [REG_W-1:0] gr7 = 3'd7;

    localparam logic [DEFAULT_IW-1:0] NOP_WORD = '0;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port and one registered read port.
// The storage itself has no reset; the owner clears it word by word.
module imem_array #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read register only updates on a read, so the last fetched word is held
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_loadable.sv
// Loadable instruction memory feeding the IF stage: clears to NOP after reset,
// accepts a program over a valid/ready stream, serves 1-cycle fetches.
// Optional per-word even parity is enabled with `define IMEM_PARITY_EN.
module imem_loadable
    import isa_pkg::*;
#(
    parameter int IW    = DEFAULT_IW,
    parameter int AW    = 16,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          r_st,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic          load_last,
    input  logic [IW-1:0] load_data,
    output logic          load_ready,
    output logic          load_done,
    output logic [AW-1:0] load_count,
    input  logic          f_en,
    input  logic [AW-1:0] f_addr,
    output logic [IW-1:0] f_instr,
    output logic          f_valid,
    output logic          f_oob,
    output logic          busy,
    output logic          f_perr
);

    localparam int IDXW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
    localparam int MW = IW + 1;
`else
    localparam int MW = IW;
`endif
    localparam logic [IW-1:0]   NOP_IW    = IW'(NOP_WORD);
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(DEPTH - 1);
    localparam logic [AW:0]     DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]     AW_MAX    = {1'b0, {AW{1'b1}}};
    localparam logic [AW:0]     COUNT_MAX = (DEPTH_W > AW_MAX) ? AW_MAX : DEPTH_W;

    typedef enum logic [1:0] {
        S_CLEAR,
        S_RUN,
        S_LOAD
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [IDXW-1:0] r_clrCnt;
    logic [IDXW-1:0] r_ptr;
    logic            r_fValid;
    logic            r_fOob;
    logic            r_zero;
    logic            r_loadDone;
    logic [AW-1:0]   r_loadCount;

    logic            w_accept;
    logic            w_lastWord;
    logic            w_fetch;
    logic            w_oob;
    logic            w_we;
    logic [IDXW-1:0] w_waddr;
    logic [IW-1:0]   w_wdataRaw;
    logic [MW-1:0]   w_wdata;
    logic [MW-1:0]   w_rdata;
    logic [AW:0]     w_words;
    logic [AW:0]     w_wordsSat;

    assign w_accept   = (r_state == S_LOAD) && load_valid;
    assign w_lastWord = w_accept && (load_last || (r_ptr == LAST_IDX));
    assign w_fetch    = (r_state == S_RUN) && f_en;
    assign w_oob      = {1'b0, f_addr} >= DEPTH_W;
    assign w_words    = (AW + 1)'(r_ptr) + (AW + 1)'(1);
    assign w_wordsSat = (w_words > COUNT_MAX) ? COUNT_MAX : w_words;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_CLEAR: if (r_clrCnt == LAST_IDX) w_stateNext = S_RUN;
            S_RUN:   if (load_start)           w_stateNext = S_LOAD;
            S_LOAD:  if (w_lastWord)           w_stateNext = S_RUN;
            default:                           w_stateNext = S_CLEAR;
        endcase
    end

    // Single write port is shared between the clear sweep and the load stream
    always_comb begin
        w_we       = 1'b0;
        w_waddr    = r_clrCnt;
        w_wdataRaw = NOP_IW;
        if (r_state == S_CLEAR) begin
            w_we = 1'b1;
        end else if (w_accept) begin
            w_we       = 1'b1;
            w_waddr    = r_ptr;
            w_wdataRaw = load_data;
        end
    end

`ifdef IMEM_PARITY_EN
    assign w_wdata = {^w_wdataRaw, w_wdataRaw};
    assign f_perr  = r_fValid && !r_fOob && (^w_rdata);
`else
    assign w_wdata = w_wdataRaw;
    assign f_perr  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (r_st) begin
            r_state     <= S_CLEAR;
            r_clrCnt    <= '0;
            r_ptr       <= '0;
            r_fValid    <= 1'b0;
            r_fOob      <= 1'b0;
            r_zero      <= 1'b1;
            r_loadDone  <= 1'b0;
            r_loadCount <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == S_CLEAR) begin
                r_clrCnt <= (r_clrCnt == LAST_IDX) ? '0 : r_clrCnt + 1'b1;
            end
            if ((r_state == S_RUN) && load_start) begin
                r_ptr <= '0;
            end else if (w_accept) begin
                r_ptr <= r_ptr + 1'b1;
            end
            r_loadDone <= w_lastWord;
            if (w_lastWord) begin
                r_loadCount <= w_wordsSat[AW-1:0];
            end
            r_fValid <= w_fetch;
            r_fOob   <= w_fetch && w_oob;
            // Outside RUN the fetch port reads as NOP; an out-of-range fetch also forces NOP
            if (r_state != S_RUN) begin
                r_zero <= 1'b1;
            end else if (f_en) begin
                r_zero <= w_oob;
            end
        end
    end

    imem_array #(
        .WIDTH (MW),
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_fetch && !w_oob),
        .i_raddr (f_addr[IDXW-1:0]),
        .o_rdata (w_rdata)
    );

    assign f_instr    = r_zero ? NOP_IW : w_rdata[IW-1:0];
    assign f_valid    = r_fValid;
    assign f_oob      = r_fOob;
    assign busy       = (r_state != S_RUN);
    assign load_ready = (r_state == S_LOAD);
    assign load_done  = r_loadDone;
    assign load_count = r_loadCount;

endmodule

// File: tb/tb_imem_loadable.sv
// Self-checking bench for imem_loadable: fetch expectations are queued when a fetch
// is driven and compared when the DUT presents the result one cycle later.
module tb_imem_loadable;

    localparam int IW    = 16;
    localparam int AW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          r_st;
    logic          load_start;
    logic          load_valid;
    logic          load_last;
    logic [IW-1:0] load_data;
    logic          load_ready;
    logic          load_done;
    logic [AW-1:0] load_count;
    logic          f_en;
    logic [AW-1:0] f_addr;
    logic [IW-1:0] f_instr;
    logic          f_valid;
    logic          f_oob;
    logic          busy;
    logic          f_perr;

    int total    = 0;
    int bad      = 0;
    int cycleCnt = 0;
    bit monOn    = 1'b0;

    logic [IW-1:0] model [DEPTH];

    typedef struct {
        int            due;
        logic [IW-1:0] instr;
        logic          oob;
        logic          perr;
    } exp_t;

    exp_t expQ[$];

    always #5 clk = ~clk;

    imem_loadable #(
        .IW    (IW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .r_st       (r_st),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_last  (load_last),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_count (load_count),
        .f_en       (f_en),
        .f_addr     (f_addr),
        .f_instr    (f_instr),
        .f_valid    (f_valid),
        .f_oob      (f_oob),
        .busy       (busy),
        .f_perr     (f_perr)
    );

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Fetch results are compared on the falling edge, away from the sampling edge
    always @(negedge clk) begin : monitor
        exp_t e;
        if (monOn) begin
            if (expQ.size() > 0 && expQ[0].due == cycleCnt) begin
                e = expQ.pop_front();
                checkOutput($sformatf("fetchValid@%0d", cycleCnt), f_valid, 1);
                checkOutput($sformatf("fetchInstr@%0d", cycleCnt), f_instr, e.instr);
                checkOutput($sformatf("fetchOob@%0d", cycleCnt), f_oob, e.oob);
                checkOutput($sformatf("fetchPerr@%0d", cycleCnt), f_perr, e.perr);
            end else begin
                checkOutput($sformatf("idleValid@%0d", cycleCnt), f_valid, 0);
                checkOutput($sformatf("idleOob@%0d", cycleCnt), f_oob, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [AW-1:0] addr, input logic perr = 1'b0);
        exp_t e;
        step();
        f_en   = 1'b1;
        f_addr = addr;
        e.due  = cycleCnt + 1;
        e.oob  = (addr >= DEPTH);
        e.instr = e.oob ? '0 : model[int'(addr)];
        e.perr = perr;
        expQ.push_back(e);
    endtask

    task automatic fetchIdle();
        step();
        f_en = 1'b0;
    endtask

    task automatic applyLoadWord(input logic [IW-1:0] data, input logic last);
        load_valid = 1'b1;
        load_data  = data;
        load_last  = last;
        step();
    endtask

    // Called right after reset is released; counts cycles until busy drops
    task automatic waitClear(input string tag);
        int n = 0;
        int dones = 0;
        do begin
            step();
            n++;
            if (load_done) dones++;
        end while (busy && n < 200);
        checkOutput(tag, n, DEPTH);
        checkOutput({tag, "NoDone"}, dones, 0);
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        r_st       = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = '0;
        f_en       = 1'b0;
        f_addr     = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstBusy", busy, 1);
        checkOutput("rstValid", f_valid, 0);
        checkOutput("rstInstr", f_instr, 0);
        checkOutput("rstOob", f_oob, 0);
        checkOutput("rstPerr", f_perr, 0);
        checkOutput("rstReady", load_ready, 0);
        checkOutput("rstDone", load_done, 0);
        checkOutput("rstCount", load_count, 0);
        r_st  = 1'b0;
        monOn = 1'b1;
        waitClear("clearCycles");

        $display("[TB] fetch whole cleared memory");
        for (int a = 0; a < DEPTH; a++) applyStimulus(AW'(a));
        fetchIdle();

        $display("[TB] short load with load_last");
        applyStimulus(16'd3);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        f_en       = 1'b0;
        checkOutput("loadReady0", load_ready, 1);
        checkOutput("loadBusy", busy, 1);
        model[0] = 16'hD100;
        applyLoadWord(16'hD100, 1'b0);
        checkOutput("loadReady1", load_ready, 1);
        model[1] = 16'h2301;
        applyLoadWord(16'h2301, 1'b1);
        load_valid = 1'b0;
        load_last  = 1'b0;
        checkOutput("shortDone", load_done, 1);
        checkOutput("shortCount", load_count, 2);
        checkOutput("shortReadyLow", load_ready, 0);
        checkOutput("shortBusyLow", busy, 0);
        step();
        checkOutput("shortDonePulse", load_done, 0);
        applyStimulus(16'd0);
        applyStimulus(16'd2);
        applyStimulus(16'd1);
        fetchIdle();
        step();
        checkOutput("holdInstr", f_instr, 16'h2301);
        checkOutput("holdValid", f_valid, 0);

        $display("[TB] 70-word stream without load_last");
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        begin
            int dones = 0;
            for (int i = 0; i < 70; i++) begin
                if (load_done) dones++;
                checkOutput($sformatf("ready70_%0d", i), load_ready, (i < DEPTH));
                if (i < DEPTH) model[i] = 16'hA000 + 16'(i);
                applyLoadWord(16'hA000 + 16'(i), 1'b0);
            end
            load_valid = 1'b0;
            if (load_done) dones++;
            checkOutput("longDones", dones, 1);
        end
        checkOutput("longCount", load_count, DEPTH);
        checkOutput("longReady", load_ready, 0);
        applyStimulus(16'd0);
        applyStimulus(16'd31);
        applyStimulus(16'd63);
        applyStimulus(16'd64);
        applyStimulus(16'hFFFF);
        applyStimulus(16'd1);
        fetchIdle();

        $display("[TB] reset during load");
        step();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) applyLoadWord(16'hB000 + 16'(i), 1'b0);
        load_valid = 1'b0;
        r_st = 1'b1;
        step();
        checkOutput("abortDone", load_done, 0);
        checkOutput("abortCount", load_count, 0);
        checkOutput("abortBusy", busy, 1);
        checkOutput("abortReady", load_ready, 0);
        r_st = 1'b0;
        waitClear("reclearCycles");
        applyStimulus(16'd0);
        applyStimulus(16'd1);
        applyStimulus(16'd2);
        applyStimulus(16'd63);
        fetchIdle();

`ifdef IMEM_PARITY_EN
        $display("[TB] parity error injection");
        step();
        dut.u_array.r_mem[5] = dut.u_array.r_mem[5] ^ 17'h1;
        applyStimulus(16'd5, 1'b1);
        applyStimulus(16'd6, 1'b0);
        applyStimulus(16'd64, 1'b0);
        fetchIdle();
`endif

        repeat (3) step();
        checkOutput("drain", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
